// File: rtl/cal_set_pkg.sv
// Shared types, seven-segment codes, error codes and calendar helpers
// for the automatic time/calendar setter.
package cal_set_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MONTH,
        ST_DATE,
        ST_DAY,
        ST_HOUR,
        ST_MIN,
        ST_DONE,
        ST_FAIL
    } state_t;

    typedef enum logic [1:0] {
        SUB_CMP,
        SUB_PULSE,
        SUB_WAIT
    } sub_t;

    // Segment order A..G maps to bits 6..0, active high.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] ERR_NONE          = 2'd0;
    localparam logic [1:0] ERR_BAD_TARGET    = 2'd1;
    localparam logic [1:0] ERR_STEP_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_BAD_SEGMENT   = 2'd3;

    function automatic logic [4:0] days_in_month(input logic [3:0] month);
        case (month)
            4'd2:                      return 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    function automatic logic [6:0] pair_value(input logic [3:0] tens, input logic [3:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

endpackage

// File: rtl/cal_set_sequencer_seg7_to_bcd.sv
// Seven-segment to BCD digit decoder. A blank display is only a legal
// digit (zero) where the caller says a leading blank may appear.
module seg7_to_bcd
    import cal_set_pkg::*;
(
    input  logic [6:0] i_seg,
    input  logic       i_blank_ok,
    output logic [3:0] o_digit,
    output logic       o_valid
);

    always_comb begin
        o_digit = 4'd0;
        o_valid = 1'b1;
        case (i_seg)
            SEG_0:     o_digit = 4'd0;
            SEG_1:     o_digit = 4'd1;
            SEG_2:     o_digit = 4'd2;
            SEG_3:     o_digit = 4'd3;
            SEG_4:     o_digit = 4'd4;
            SEG_5:     o_digit = 4'd5;
            SEG_6:     o_digit = 4'd6;
            SEG_7:     o_digit = 4'd7;
            SEG_8:     o_digit = 4'd8;
            SEG_9:     o_digit = 4'd9;
            SEG_BLANK: o_valid = i_blank_ok;
            default:   o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/cal_set_sequencer.sv
// Drives the clock's set-mode interface: reads the displays back and pulses
// each field's advance input until month, date, day, hour and minute match.
module cal_set_sequencer
    import cal_set_pkg::*;
#(
    parameter int SETTLE    = 3,
    parameter int MAX_STEPS = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [3:0] i_tgt_month,
    input  logic [4:0] i_tgt_date,
    input  logic [2:0] i_tgt_day,
    input  logic [4:0] i_tgt_hrs,
    input  logic [5:0] i_tgt_min,
    input  logic [6:0] i_month1_disp,
    input  logic [6:0] i_month0_disp,
    input  logic [6:0] i_date1_disp,
    input  logic [6:0] i_date0_disp,
    input  logic [6:0] i_d0_disp,
    input  logic [6:0] i_h1_disp,
    input  logic [6:0] i_h0_disp,
    input  logic [6:0] i_m1_disp,
    input  logic [6:0] i_m0_disp,
    output logic       o_timeset,
    output logic       o_month_adv,
    output logic       o_date_adv,
    output logic       o_day_adv,
    output logic       o_hrs_adv,
    output logic       o_min_adv,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    // Display index: 0 Month1, 1 Month0, 2 Date1, 3 Date0, 4 D0,
    // 5 H1, 6 H0, 7 M1, 8 M0. Tens positions may show a blank.
    localparam int         NUM_DISP      = 9;
    localparam logic [8:0] BLANK_OK_MASK = 9'b010100101;
    localparam logic [7:0] WAIT_LAST     = 8'(SETTLE - 1);
    localparam logic [7:0] STEP_LIMIT    = 8'(MAX_STEPS);

    state_t      r_state, r_state_next;
    sub_t        r_sub, r_sub_next;
    logic [7:0]  r_wait_cnt, r_wait_cnt_next;
    logic [7:0]  r_step_cnt, r_step_cnt_next;
    logic [3:0]  r_tgt_month, r_tgt_month_next;
    logic [4:0]  r_tgt_date, r_tgt_date_next;
    logic [2:0]  r_tgt_day, r_tgt_day_next;
    logic [4:0]  r_tgt_hrs, r_tgt_hrs_next;
    logic [5:0]  r_tgt_min, r_tgt_min_next;
    logic        r_err, r_err_next;
    logic [1:0]  r_err_code, r_err_code_next;

    logic [6:0]  w_seg [NUM_DISP];
    logic [3:0]  w_digit [NUM_DISP];
    logic [8:0]  w_digit_ok;
    logic [6:0]  w_month_val, w_date_val, w_day_val, w_hrs_val, w_min_val;
    logic [6:0]  w_field_val, w_field_tgt;
    logic        w_field_ok;
    logic        w_field_match;
    logic        w_tgt_ok;
    logic        w_adv;
    state_t      w_next_field;

    assign w_seg[0] = i_month1_disp;
    assign w_seg[1] = i_month0_disp;
    assign w_seg[2] = i_date1_disp;
    assign w_seg[3] = i_date0_disp;
    assign w_seg[4] = i_d0_disp;
    assign w_seg[5] = i_h1_disp;
    assign w_seg[6] = i_h0_disp;
    assign w_seg[7] = i_m1_disp;
    assign w_seg[8] = i_m0_disp;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DISP; gi++) begin : g_dec
            seg7_to_bcd u_dec (
                .i_seg      (w_seg[gi]),
                .i_blank_ok (BLANK_OK_MASK[gi]),
                .o_digit    (w_digit[gi]),
                .o_valid    (w_digit_ok[gi])
            );
        end
    endgenerate

    assign w_month_val = pair_value(w_digit[0], w_digit[1]);
    assign w_date_val  = pair_value(w_digit[2], w_digit[3]);
    assign w_day_val   = {3'b000, w_digit[4]};
    assign w_hrs_val   = pair_value(w_digit[5], w_digit[6]);
    assign w_min_val   = pair_value(w_digit[7], w_digit[8]);

    always_comb begin
        w_field_val  = 7'd0;
        w_field_tgt  = 7'd0;
        w_field_ok   = 1'b0;
        w_next_field = ST_DONE;
        case (r_state)
            ST_MONTH: begin
                w_field_val  = w_month_val;
                w_field_tgt  = {3'b000, r_tgt_month};
                w_field_ok   = &w_digit_ok[1:0];
                w_next_field = ST_DATE;
            end
            ST_DATE: begin
                w_field_val  = w_date_val;
                w_field_tgt  = {2'b00, r_tgt_date};
                w_field_ok   = &w_digit_ok[3:2];
                w_next_field = ST_DAY;
            end
            ST_DAY: begin
                w_field_val  = w_day_val;
                w_field_tgt  = {4'b0000, r_tgt_day};
                w_field_ok   = w_digit_ok[4];
                w_next_field = ST_HOUR;
            end
            ST_HOUR: begin
                w_field_val  = w_hrs_val;
                w_field_tgt  = {2'b00, r_tgt_hrs};
                w_field_ok   = &w_digit_ok[6:5];
                w_next_field = ST_MIN;
            end
            ST_MIN: begin
                w_field_val  = w_min_val;
                w_field_tgt  = {1'b0, r_tgt_min};
                w_field_ok   = &w_digit_ok[8:7];
                w_next_field = ST_DONE;
            end
            default: ;
        endcase
    end

    assign w_field_match = (w_field_val == w_field_tgt);

    assign w_tgt_ok = (r_tgt_month >= 4'd1) && (r_tgt_month <= 4'd12) &&
                      (r_tgt_hrs <= 5'd23) && (r_tgt_min <= 6'd59) &&
                      (r_tgt_day <= 3'd6) && (r_tgt_date != 5'd0) &&
                      (r_tgt_date <= days_in_month(r_tgt_month));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_sub       <= SUB_CMP;
            r_wait_cnt  <= 8'd0;
            r_step_cnt  <= 8'd0;
            r_tgt_month <= 4'd0;
            r_tgt_date  <= 5'd0;
            r_tgt_day   <= 3'd0;
            r_tgt_hrs   <= 5'd0;
            r_tgt_min   <= 6'd0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= r_state_next;
            r_sub       <= r_sub_next;
            r_wait_cnt  <= r_wait_cnt_next;
            r_step_cnt  <= r_step_cnt_next;
            r_tgt_month <= r_tgt_month_next;
            r_tgt_date  <= r_tgt_date_next;
            r_tgt_day   <= r_tgt_day_next;
            r_tgt_hrs   <= r_tgt_hrs_next;
            r_tgt_min   <= r_tgt_min_next;
            r_err       <= r_err_next;
            r_err_code  <= r_err_code_next;
        end
    end

    always_comb begin
        r_state_next     = r_state;
        r_sub_next       = r_sub;
        r_wait_cnt_next  = r_wait_cnt;
        r_step_cnt_next  = r_step_cnt;
        r_tgt_month_next = r_tgt_month;
        r_tgt_date_next  = r_tgt_date;
        r_tgt_day_next   = r_tgt_day;
        r_tgt_hrs_next   = r_tgt_hrs;
        r_tgt_min_next   = r_tgt_min;
        r_err_next       = r_err;
        r_err_code_next  = r_err_code;
        o_timeset        = 1'b0;
        o_busy           = (r_state != ST_IDLE);
        o_done           = 1'b0;
        w_adv            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    r_tgt_month_next = i_tgt_month;
                    r_tgt_date_next  = i_tgt_date;
                    r_tgt_day_next   = i_tgt_day;
                    r_tgt_hrs_next   = i_tgt_hrs;
                    r_tgt_min_next   = i_tgt_min;
                    r_err_next       = 1'b0;
                    r_err_code_next  = ERR_NONE;
                    r_state_next     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                o_timeset       = 1'b1;
                r_sub_next      = SUB_CMP;
                r_step_cnt_next = 8'd0;
                if (w_tgt_ok) begin
                    r_state_next = ST_MONTH;
                end else begin
                    r_state_next    = ST_FAIL;
                    r_err_next      = 1'b1;
                    r_err_code_next = ERR_BAD_TARGET;
                end
            end
            ST_MONTH, ST_DATE, ST_DAY, ST_HOUR, ST_MIN: begin
                o_timeset = 1'b1;
                case (r_sub)
                    SUB_CMP: begin
                        if (!w_field_ok) begin
                            r_state_next    = ST_FAIL;
                            r_err_next      = 1'b1;
                            r_err_code_next = ERR_BAD_SEGMENT;
                        end else if (w_field_match) begin
                            r_state_next    = w_next_field;
                            r_step_cnt_next = 8'd0;
                        end else if (r_step_cnt >= STEP_LIMIT) begin
                            r_state_next    = ST_FAIL;
                            r_err_next      = 1'b1;
                            r_err_code_next = ERR_STEP_OVERFLOW;
                        end else begin
                            r_sub_next = SUB_PULSE;
                        end
                    end
                    SUB_PULSE: begin
                        w_adv           = 1'b1;
                        r_step_cnt_next = r_step_cnt + 8'd1;
                        r_wait_cnt_next = 8'd0;
                        r_sub_next      = SUB_WAIT;
                    end
                    SUB_WAIT: begin
                        // Give the clock's display path time to show the new value.
                        if (r_wait_cnt == WAIT_LAST) begin
                            r_sub_next = SUB_CMP;
                        end else begin
                            r_wait_cnt_next = r_wait_cnt + 8'd1;
                        end
                    end
                    default: r_sub_next = SUB_CMP;
                endcase
            end
            ST_DONE: begin
                o_done       = 1'b1;
                r_state_next = ST_IDLE;
            end
            ST_FAIL: begin
                r_state_next = ST_IDLE;
            end
            default: r_state_next = ST_IDLE;
        endcase

        // Abort wins over whatever the current state would have done this cycle.
        if (i_abort && (r_state != ST_IDLE)) begin
            r_state_next    = ST_IDLE;
            r_sub_next      = SUB_CMP;
            r_step_cnt_next = r_step_cnt;
            r_err_next      = r_err;
            r_err_code_next = r_err_code;
            w_adv           = 1'b0;
            o_done          = 1'b0;
        end
    end

    assign o_month_adv = w_adv && (r_state == ST_MONTH);
    assign o_date_adv  = w_adv && (r_state == ST_DATE);
    assign o_day_adv   = w_adv && (r_state == ST_DAY);
    assign o_hrs_adv   = w_adv && (r_state == ST_HOUR);
    assign o_min_adv   = w_adv && (r_state == ST_MIN);
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_cal_set_sequencer.sv
// Directed bench: a small behavioural clock model answers the advance pulses
// through its seven-segment displays; each task checks one scenario.
module tb_cal_set_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] tgt_month = 4'd1;
    logic [4:0] tgt_date = 5'd1;
    logic [2:0] tgt_day = 3'd0;
    logic [4:0] tgt_hrs = 5'd0;
    logic [5:0] tgt_min = 6'd0;
    logic [6:0] month1_disp, month0_disp, date1_disp, date0_disp, d0_disp;
    logic [6:0] h1_disp, h0_disp, m1_disp, m0_disp;
    logic       timeset, month_adv, date_adv, day_adv, hrs_adv, min_adv;
    logic       busy, done, err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cal_set_sequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_abort       (abort),
        .i_tgt_month   (tgt_month),
        .i_tgt_date    (tgt_date),
        .i_tgt_day     (tgt_day),
        .i_tgt_hrs     (tgt_hrs),
        .i_tgt_min     (tgt_min),
        .i_month1_disp (month1_disp),
        .i_month0_disp (month0_disp),
        .i_date1_disp  (date1_disp),
        .i_date0_disp  (date0_disp),
        .i_d0_disp     (d0_disp),
        .i_h1_disp     (h1_disp),
        .i_h0_disp     (h0_disp),
        .i_m1_disp     (m1_disp),
        .i_m0_disp     (m0_disp),
        .o_timeset     (timeset),
        .o_month_adv   (month_adv),
        .o_date_adv    (date_adv),
        .o_day_adv     (day_adv),
        .o_hrs_adv     (hrs_adv),
        .o_min_adv     (min_adv),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .o_err_code    (err_code)
    );

    // ---------------- behavioural clock model ----------------
    logic [3:0] m_month, ld_month;
    logic [4:0] m_date, ld_date;
    logic [2:0] m_day, ld_day;
    logic [4:0] m_hrs, ld_hrs;
    logic [5:0] m_min, ld_min;
    logic       ld = 1'b0;
    logic       ignore_date = 1'b0;
    logic       bad_m0 = 1'b0;

    function automatic logic [4:0] tb_dim(input logic [3:0] mo);
        if (mo == 4'd2) return 5'd28;
        if (mo == 4'd4 || mo == 4'd6 || mo == 4'd9 || mo == 4'd11) return 5'd30;
        return 5'd31;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
            4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
            8: return 7'h7F;  9: return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] tens_seg(input int v, input bit blank_zero);
        if (blank_zero && (v / 10) == 0) return 7'h00;
        return seg_of(v / 10);
    endfunction

    always @(posedge clk) begin
        if (ld) begin
            m_month <= ld_month;
            m_date  <= ld_date;
            m_day   <= ld_day;
            m_hrs   <= ld_hrs;
            m_min   <= ld_min;
        end else begin
            if (month_adv) m_month <= (m_month == 4'd12) ? 4'd1 : m_month + 4'd1;
            if (date_adv && !ignore_date) m_date <= (m_date >= tb_dim(m_month)) ? 5'd1 : m_date + 5'd1;
            if (day_adv) m_day <= (m_day == 3'd6) ? 3'd0 : m_day + 3'd1;
            if (hrs_adv) m_hrs <= (m_hrs == 5'd23) ? 5'd0 : m_hrs + 5'd1;
            if (min_adv) m_min <= (m_min == 6'd59) ? 6'd0 : m_min + 6'd1;
        end
    end

    assign month1_disp = tens_seg(int'(m_month), 1'b1);
    assign month0_disp = seg_of(int'(m_month) % 10);
    assign date1_disp  = tens_seg(int'(m_date), 1'b1);
    assign date0_disp  = seg_of(int'(m_date) % 10);
    assign d0_disp     = seg_of(int'(m_day));
    assign h1_disp     = tens_seg(int'(m_hrs), 1'b0);
    assign h0_disp     = seg_of(int'(m_hrs) % 10);
    assign m1_disp     = tens_seg(int'(m_min), 1'b0);
    assign m0_disp     = bad_m0 ? 7'h01 : seg_of(int'(m_min) % 10);

    // ---------------- output monitor ----------------
    logic [4:0] advs;
    assign advs = {month_adv, date_adv, day_adv, hrs_adv, min_adv};

    int  cyc = 0, last_adv = 0;
    int  n_madv = 0, n_dadv = 0, n_dyadv = 0, n_hadv = 0, n_minadv = 0;
    int  n_done = 0, excl_viol = 0, gap_viol = 0, ts_cycles = 0, ts_rises = 0;
    bit  have_last = 1'b0, prev_ts = 1'b0, clr_mon = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (clr_mon) begin
            n_madv <= 0; n_dadv <= 0; n_dyadv <= 0; n_hadv <= 0; n_minadv <= 0;
            n_done <= 0; excl_viol <= 0; gap_viol <= 0; ts_cycles <= 0; ts_rises <= 0;
            have_last <= 1'b0; prev_ts <= 1'b0;
        end else begin
            n_madv   <= n_madv   + (month_adv ? 1 : 0);
            n_dadv   <= n_dadv   + (date_adv  ? 1 : 0);
            n_dyadv  <= n_dyadv  + (day_adv   ? 1 : 0);
            n_hadv   <= n_hadv   + (hrs_adv   ? 1 : 0);
            n_minadv <= n_minadv + (min_adv   ? 1 : 0);
            if ($countones(advs) > 1) excl_viol <= excl_viol + 1;
            if (|advs) begin
                if (have_last && (cyc - last_adv) < 4) gap_viol <= gap_viol + 1;
                last_adv  <= cyc;
                have_last <= 1'b1;
            end
            if (done) n_done <= n_done + 1;
            if (timeset) ts_cycles <= ts_cycles + 1;
            if (timeset && !prev_ts) ts_rises <= ts_rises + 1;
            prev_ts <= timeset;
        end
    end

    // ---------------- helpers ----------------
    task automatic load_clock(input logic [3:0] mo, input logic [4:0] da, input logic [2:0] dy,
                              input logic [4:0] hr, input logic [5:0] mi);
        ld_month = mo; ld_date = da; ld_day = dy; ld_hrs = hr; ld_min = mi;
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    task automatic clear_mon();
        clr_mon = 1'b1;
        @(negedge clk); #1;
        clr_mon = 1'b0;
    endtask

    task automatic start_op(input logic [3:0] mo, input logic [4:0] da, input logic [2:0] dy,
                            input logic [4:0] hr, input logic [5:0] mi);
        tgt_month = mo; tgt_date = da; tgt_day = dy; tgt_hrs = hr; tgt_min = mi;
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, expected 0", tag, busy, n);
        end
    endtask

    task automatic run_op(input logic [3:0] mo, input logic [4:0] da, input logic [2:0] dy,
                          input logic [4:0] hr, input logic [5:0] mi, input string tag);
        start_op(mo, da, dy, hr, mi);
        wait_idle(tag);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        load_clock(4'd1, 5'd1, 3'd0, 5'd0, 6'd0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({timeset, advs, busy, done, err, err_code} !== 11'd0) begin
            errors++;
            $display("FAIL reset_held outputs: got %b expected 0", {timeset, advs, busy, done, err, err_code});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({timeset, advs, busy, done, err, err_code} !== 11'd0) begin
            errors++;
            $display("FAIL reset_released outputs: got %b expected 0", {timeset, advs, busy, done, err, err_code});
        end
        $display("test_reset: outputs idle in and after reset");
    endtask

    task automatic test_full_set();
        load_clock(4'd1, 5'd1, 3'd0, 5'd0, 6'd0);
        run_op(4'd12, 5'd31, 3'd3, 5'd23, 6'd59, "full_set");
        checks++;
        if (n_madv != 11) begin errors++; $display("FAIL full_set month_adv: got %0d expected 11", n_madv); end
        checks++;
        if (n_dadv != 30) begin errors++; $display("FAIL full_set date_adv: got %0d expected 30", n_dadv); end
        checks++;
        if (n_dyadv != 3) begin errors++; $display("FAIL full_set day_adv: got %0d expected 3", n_dyadv); end
        checks++;
        if (n_hadv != 23) begin errors++; $display("FAIL full_set hrs_adv: got %0d expected 23", n_hadv); end
        checks++;
        if (n_minadv != 59) begin errors++; $display("FAIL full_set min_adv: got %0d expected 59", n_minadv); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL full_set done pulses: got %0d expected 1", n_done); end
        checks++;
        if (excl_viol != 0 || gap_viol != 0) begin
            errors++;
            $display("FAIL full_set pulse spacing: excl=%0d gap=%0d expected 0/0", excl_viol, gap_viol);
        end
        checks++;
        if (ts_rises != 1) begin errors++; $display("FAIL full_set timeset rises: got %0d expected 1", ts_rises); end
        checks++;
        if (err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL full_set err: got %b/%0d expected 0/0", err, err_code);
        end
        checks++;
        if ({m_month, m_date, m_day, m_hrs, m_min} !== {4'd12, 5'd31, 3'd3, 5'd23, 6'd59}) begin
            errors++;
            $display("FAIL full_set clock: got %0d/%0d d%0d %0d:%0d expected 12/31 d3 23:59",
                     m_month, m_date, m_day, m_hrs, m_min);
        end
        $display("test_full_set: %0d/%0d/%0d/%0d/%0d pulses, done=%0d", n_madv, n_dadv, n_dyadv, n_hadv, n_minadv, n_done);
    endtask

    task automatic test_bad_target();
        load_clock(4'd1, 5'd1, 3'd0, 5'd0, 6'd0);
        run_op(4'd2, 5'd29, 3'd0, 5'd0, 6'd0, "bad_target");
        checks++;
        if (err !== 1'b1 || err_code !== 2'd1) begin
            errors++;
            $display("FAIL bad_target err: got %b/%0d expected 1/1", err, err_code);
        end
        checks++;
        if (n_madv + n_dadv + n_dyadv + n_hadv + n_minadv != 0) begin
            errors++;
            $display("FAIL bad_target adv pulses: got %0d expected 0", n_madv + n_dadv + n_dyadv + n_hadv + n_minadv);
        end
        checks++;
        if (ts_cycles != 1) begin errors++; $display("FAIL bad_target timeset cycles: got %0d expected 1", ts_cycles); end
        checks++;
        if (n_done != 0) begin errors++; $display("FAIL bad_target done pulses: got %0d expected 0", n_done); end
        $display("test_bad_target: err=%b code=%0d timeset cycles=%0d", err, err_code, ts_cycles);
    endtask

    task automatic test_wrap();
        load_clock(4'd12, 5'd5, 3'd0, 5'd10, 6'd10);
        run_op(4'd3, 5'd5, 3'd0, 5'd10, 6'd10, "wrap_month");
        checks++;
        if (n_madv != 3 || n_dadv + n_dyadv + n_hadv + n_minadv != 0) begin
            errors++;
            $display("FAIL wrap_month pulses: got month=%0d others=%0d expected 3/0",
                     n_madv, n_dadv + n_dyadv + n_hadv + n_minadv);
        end
        checks++;
        if (n_done != 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_month result: got done=%0d err=%b expected 1/0", n_done, err);
        end
        $display("test_wrap: 12->3 took %0d month pulses", n_madv);
        run_op(4'd4, 5'd30, 3'd0, 5'd10, 6'd10, "apr30");
        checks++;
        if (n_madv != 1 || n_dadv != 25) begin
            errors++;
            $display("FAIL apr30 pulses: got month=%0d date=%0d expected 1/25", n_madv, n_dadv);
        end
        checks++;
        if (n_done != 1 || err !== 1'b0 || m_date !== 5'd30) begin
            errors++;
            $display("FAIL apr30 result: got done=%0d err=%b date=%0d expected 1/0/30", n_done, err, m_date);
        end
        $display("test_wrap: 04/30 accepted, date pulses=%0d", n_dadv);
    endtask

    task automatic test_overflow();
        load_clock(4'd1, 5'd1, 3'd0, 5'd0, 6'd0);
        ignore_date = 1'b1;
        run_op(4'd1, 5'd15, 3'd0, 5'd0, 6'd0, "overflow");
        ignore_date = 1'b0;
        checks++;
        if (n_dadv != 64) begin errors++; $display("FAIL overflow date_adv: got %0d expected 64", n_dadv); end
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2) begin
            errors++;
            $display("FAIL overflow err: got %b/%0d expected 1/2", err, err_code);
        end
        checks++;
        if (timeset !== 1'b0 || n_done != 0) begin
            errors++;
            $display("FAIL overflow end: got timeset=%b done=%0d expected 0/0", timeset, n_done);
        end
        $display("test_overflow: %0d date pulses, code=%0d", n_dadv, err_code);
    endtask

    task automatic test_abort();
        bit         found;
        logic [4:0] h_snap;
        load_clock(4'd1, 5'd1, 3'd0, 5'd0, 6'd0);
        start_op(4'd1, 5'd1, 3'd0, 5'd20, 6'd0);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (hrs_adv) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort hrs_adv seen: got 0 expected 1"); end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || timeset !== 1'b0 || advs !== 5'd0) begin
            errors++;
            $display("FAIL abort next cycle: got busy=%b timeset=%b adv=%b expected 0/0/0", busy, timeset, advs);
        end
        h_snap = m_hrs;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (n_done != 0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort quiet: got done=%0d err=%b busy=%b expected 0/0/0", n_done, err, busy);
        end
        run_op(4'd1, 5'd1, 3'd0, 5'd20, 6'd0, "abort_restart");
        checks++;
        if (n_done != 1 || m_hrs !== 5'd20 || n_hadv != 20 - int'(h_snap)) begin
            errors++;
            $display("FAIL abort_restart: got done=%0d hrs=%0d hrs_adv=%0d expected 1/20/%0d",
                     n_done, m_hrs, n_hadv, 20 - int'(h_snap));
        end
        $display("test_abort: aborted at hour %0d, restart done=%0d", h_snap, n_done);
    endtask

    task automatic test_reset_mid();
        bit found;
        load_clock(4'd1, 5'd1, 3'd0, 5'd0, 6'd0);
        start_op(4'd1, 5'd20, 3'd0, 5'd0, 6'd0);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (date_adv) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reset_mid date_adv seen: got 0 expected 1"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({timeset, advs, busy, done, err, err_code} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid async: got %b expected 0", {timeset, advs, busy, done, err, err_code});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || timeset !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid after release: got busy=%b timeset=%b expected 0/0", busy, timeset);
        end
        $display("test_reset_mid: outputs cleared during date pulse");
    endtask

    task automatic test_bad_segment();
        load_clock(4'd1, 5'd1, 3'd0, 5'd0, 6'd0);
        bad_m0 = 1'b1;
        run_op(4'd1, 5'd1, 3'd0, 5'd5, 6'd0, "bad_segment");
        bad_m0 = 1'b0;
        checks++;
        if (err !== 1'b1 || err_code !== 2'd3) begin
            errors++;
            $display("FAIL bad_segment err: got %b/%0d expected 1/3", err, err_code);
        end
        checks++;
        if (n_hadv != 5 || n_minadv != 0 || n_done != 0) begin
            errors++;
            $display("FAIL bad_segment pulses: got hrs=%0d min=%0d done=%0d expected 5/0/0", n_hadv, n_minadv, n_done);
        end
        $display("test_bad_segment: code=%0d after %0d hour pulses", err_code, n_hadv);
    endtask

    initial begin
        test_reset();
        test_full_set();
        test_bad_target();
        test_wrap();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_bad_segment();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
